// File: rtl/array_mcp2_ctrl.sv
// Two-cycle sequencer for the 512x512 MCP2 single-port array macro.
// Define MCP2_RESP_SKID_EN for a 2-entry read response buffer.
module array_mcp2_ctrl #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 512
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic [ADDR_W-1:0] RW0_addr,
  output logic              RW0_en,
  output logic              RW0_wmode,
  output logic [DATA_W-1:0] RW0_wdata,
  input  logic [DATA_W-1:0] RW0_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC1 = 2'd1,
    ACC2 = 2'd2
  } state_e;

  state_e            state_q;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic acc;
  logic cap;
  logic pop;
  logic free;

  assign pop       = resp_valid && resp_ready;
  assign cap       = (state_q == ACC2) && !wr_q;
  assign req_ready = reset_n && (state_q == IDLE)
                     && (req_write || free);
  assign acc       = req_valid && req_ready;

  assign RW0_addr  = addr_q;
  assign RW0_wmode = wr_q;
  assign RW0_wdata = wdata_q;
  assign RW0_en    = (state_q == ACC1);
  assign busy      = (state_q != IDLE);

  // Hold registers only move on accept, keeping the macro pins stable.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (acc) begin
            state_q <= ACC1;
            wr_q    <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
          end
        end
        ACC1:    state_q <= ACC2;
        ACC2:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef MCP2_RESP_SKID_EN
  logic [1:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] skid_q, skid_d;

  assign free       = (cnt_q != 2'd2) || pop;
  assign resp_valid = (cnt_q != 2'd0);
  assign resp_data  = head_q;

  always_comb begin
    cnt_d  = cnt_q;
    head_d = head_q;
    skid_d = skid_q;
    unique case ({cap, pop})
      2'b11: begin
        if (cnt_q == 2'd2) begin
          head_d = skid_q;
          skid_d = RW0_rdata;
        end else begin
          head_d = RW0_rdata;
        end
      end
      2'b10: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd0) head_d = RW0_rdata;
        else               skid_d = RW0_rdata;
      end
      2'b01: begin
        cnt_d = cnt_q - 2'd1;
        if (cnt_q == 2'd2) head_d = skid_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= 2'd0;
      head_q <= '0;
      skid_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      head_q <= head_d;
      skid_q <= skid_d;
    end
  end
`else
  logic              vld_q, vld_d;
  logic [DATA_W-1:0] head_q, head_d;

  assign free       = !vld_q || pop;
  assign resp_valid = vld_q;
  assign resp_data  = head_q;

  always_comb begin
    vld_d  = vld_q;
    head_d = head_q;
    if (cap) begin
      vld_d  = 1'b1;
      head_d = RW0_rdata;
    end else if (pop) begin
      vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_q  <= 1'b0;
      head_q <= '0;
    end else begin
      vld_q  <= vld_d;
      head_q <= head_d;
    end
  end
`endif

endmodule
